// File: rtl/ad7980_sample_ctrl_if.sv
// Handshake/status bundle between the AD7980 sample scheduler and its neighbours.
// Optional m_tstamp appears when AD7980_SAMPLE_CTRL_TSTAMP_EN is defined.
interface ad7980_sample_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              stop;
    logic [DIV_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_count;
    logic              adc_start;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic [CNT_W-1:0]  overrun_cnt;
    logic [CNT_W-1:0]  missed_cnt;
`ifdef AD7980_SAMPLE_CTRL_TSTAMP_EN
    logic [31:0]       m_tstamp;
`endif

    modport slave (
        input  start, stop, cfg_period, cfg_count,
        input  adc_data, adc_valid, m_ready,
        output adc_start, m_data, m_valid,
        output busy, done, err_timeout,
        output overrun_cnt, missed_cnt
`ifdef AD7980_SAMPLE_CTRL_TSTAMP_EN
        , output m_tstamp
`endif
    );

    modport master (
        output start, stop, cfg_period, cfg_count,
        output adc_data, adc_valid, m_ready,
        input  adc_start, m_data, m_valid,
        input  busy, done, err_timeout,
        input  overrun_cnt, missed_cnt
`ifdef AD7980_SAMPLE_CTRL_TSTAMP_EN
        , input m_tstamp
`endif
    );
endinterface

// File: rtl/ad7980_sample_ctrl.sv
// AD7980 conversion scheduler: periodic requests, bursts, 1-entry output reg.
// Define AD7980_SAMPLE_CTRL_TSTAMP_EN to add a request timestamp (m_tstamp).
module ad7980_sample_ctrl #(
    parameter int DATA_W  = 16,
    parameter int DIV_W   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    ad7980_sample_ctrl_if.slave bus
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CONV  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        r_state;
    logic [DIV_W-1:0]  r_period;
    logic [DIV_W-1:0]  r_pcnt;
    logic [CNT_W-1:0]  r_rem;
    logic              r_cont;
    logic [TO_W-1:0]   r_tcnt;
    logic              r_done;
    logic              r_err;
    logic [CNT_W-1:0]  r_ovr;
    logic [CNT_W-1:0]  r_miss;
    logic [DATA_W-1:0] r_mdata;
    logic              r_mvalid;

    logic w_run;
    logic w_tick;
    logic w_start;
    logic w_issue;
    logic w_inflt;
    logic w_tmo;
    logic w_cvalid;
    logic w_room;
    logic w_load;
    logic w_drop;
    logic w_last;
    logic w_miss;

    assign w_run    = (r_state == ST_WAIT) || (r_state == ST_CONV);
    assign w_tick   = w_run && (r_pcnt == r_period);
    assign w_start  = (r_state == ST_IDLE) && bus.start && !bus.stop;
    assign w_issue  = (r_state == ST_WAIT) && w_tick && !bus.stop;
    assign w_inflt  = (r_state == ST_CONV) || (r_state == ST_DRAIN);
    assign w_tmo    = w_inflt && !bus.adc_valid
                    && (r_tcnt == TO_W'(TIMEOUT - 1));
    assign w_cvalid = (r_state == ST_CONV) && bus.adc_valid && !bus.stop;
    assign w_room   = !r_mvalid || bus.m_ready;
    assign w_load   = w_cvalid && w_room;
    assign w_drop   = w_cvalid && !w_room;
    assign w_last   = w_cvalid && !r_cont && (r_rem == CNT_W'(1));
    assign w_miss   = (r_state == ST_CONV) && w_tick;

    // Run/burst state machine; done is a registered one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_period <= '0;
            r_rem    <= '0;
            r_cont   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_period <= bus.cfg_period;
                        r_rem    <= bus.cfg_count;
                        r_cont   <= (bus.cfg_count == '0);
                        r_err    <= 1'b0;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.stop) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (bus.stop) begin
                        // a result landing with the stop is the drained one
                        if (bus.adc_valid || w_tmo) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (bus.adc_valid) begin
                        if (!r_cont) begin
                            r_rem <= r_rem - CNT_W'(1);
                        end
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.adc_valid || w_tmo) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sample-period divider, free-running while a run is active
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (!w_run || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + DIV_W'(1);
        end
    end

    // Cycles since the request; the request cycle itself counts as one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_issue) begin
            r_tcnt <= TO_W'(1);
        end else if (w_inflt) begin
            r_tcnt <= r_tcnt + TO_W'(1);
        end else begin
            r_tcnt <= '0;
        end
    end

    // Saturating overrun and missed-tick counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr  <= '0;
            r_miss <= '0;
        end else if (w_start) begin
            r_ovr  <= '0;
            r_miss <= '0;
        end else begin
            if (w_drop && (r_ovr != '1)) begin
                r_ovr <= r_ovr + CNT_W'(1);
            end
            if (w_miss && (r_miss != '1)) begin
                r_miss <= r_miss + CNT_W'(1);
            end
        end
    end

    // One-entry output holding register, independent of run state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mdata  <= '0;
            r_mvalid <= 1'b0;
        end else if (w_load) begin
            r_mdata  <= bus.adc_data;
            r_mvalid <= 1'b1;
        end else if (r_mvalid && bus.m_ready) begin
            r_mvalid <= 1'b0;
        end
    end

`ifdef AD7980_SAMPLE_CTRL_TSTAMP_EN
    logic [31:0] r_cycle;
    logic [31:0] r_req_ts;
    logic [31:0] r_mts;

    // Free-running cycle counter, snapshot at request, moved with the data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle  <= '0;
            r_req_ts <= '0;
            r_mts    <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_issue) begin
                r_req_ts <= r_cycle;
            end
            if (w_load) begin
                r_mts <= r_req_ts;
            end
        end
    end

    assign bus.m_tstamp = r_mts;
`endif

    assign bus.adc_start   = w_issue;
    assign bus.m_data      = r_mdata;
    assign bus.m_valid     = r_mvalid;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = r_done;
    assign bus.err_timeout = r_err;
    assign bus.overrun_cnt = r_ovr;
    assign bus.missed_cnt  = r_miss;
endmodule

// File: tb/tb_ad7980_sample_ctrl.sv
// Bench for ad7980_sample_ctrl: burst table, random bursts vs timing model,
// and hand sequences for timeout, drain, stop/start and reset.
module tb_ad7980_sample_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ad7980_sample_ctrl_if bus ();

    ad7980_sample_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int per;
        int cnt;
        int lat;
        int rdy;
        int nst;
        int first;
        int space;
        int missed;
        int ovr;
    } vec_t;

    int vec = 0;
    int errs = 0;
    int cyc_n = 0;
    int lat;
    int rdy_mode;
    int resp_due;
    int exp_ovr;
    logic resp_pend;
    logic mdl_accept;
    logic exp_mv;
    logic [15:0] exp_md;
    logic [15:0] resp_dat;
    logic [15:0] dat_q[$];
    logic [15:0] xfer_q[$];
    logic [15:0] deliv_q[$];
    int st_q[$];
    int dn_q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    // One clock cycle: drive ADC model, sample outputs, update reference
    task automatic cyc();
        case (rdy_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(0, 1));
        endcase
        if (resp_pend && cyc_n >= resp_due) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = resp_dat;
            resp_pend     = 1'b0;
        end else begin
            bus.adc_valid = 1'b0;
            bus.adc_data  = 16'($urandom);
        end
        #3;
        chk("m_valid", bus.m_valid, exp_mv);
        if (exp_mv) chk("m_data", bus.m_data, exp_md);
        if (bus.adc_start) begin
            st_q.push_back(cyc_n);
            if (lat > 0 && !resp_pend) begin
                resp_pend = 1'b1;
                resp_due  = cyc_n + lat;
                resp_dat  = (dat_q.size() > 0) ? dat_q.pop_front()
                                               : 16'($urandom);
            end
        end
        if (bus.done) dn_q.push_back(cyc_n);
        if (bus.m_valid && bus.m_ready) xfer_q.push_back(bus.m_data);
        if (bus.adc_valid && mdl_accept) begin
            if (!exp_mv || bus.m_ready) begin
                exp_mv = 1'b1;
                exp_md = bus.adc_data;
                deliv_q.push_back(bus.adc_data);
            end else begin
                exp_ovr++;
            end
        end else if (exp_mv && bus.m_ready) begin
            exp_mv = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic start_run(input int p, input int n, input int l,
                             input int rm, input logic acc, output int s);
        bus.cfg_period = 16'(p);
        bus.cfg_count  = 16'(n);
        lat        = l;
        rdy_mode   = rm;
        mdl_accept = acc;
        st_q.delete();
        dn_q.delete();
        xfer_q.delete();
        deliv_q.delete();
        exp_ovr   = 0;
        bus.start = 1'b1;
        s = cyc_n;
        cyc();
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && dn_q.size() == 0; k++) cyc();
        chk("done_seen", dn_q.size(), 1);
    endtask

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -100000;
    endfunction

    function automatic int last_of(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -100000;
    endfunction

    vec_t tbl[5];
    logic [15:0] tdat[4];

    initial begin
        int s;
        int r;
        int c;
        int m;
        tbl[0] = '{9, 3, 8,  1, 3, 10, 10, 0, 0};
        tbl[1] = '{4, 2, 12, 1, 2, 5,  15, 4, 0};
        tbl[2] = '{6, 4, 3,  0, 4, 7,  7,  0, 3};
        tbl[3] = '{0, 3, 2,  1, 3, 1,  3,  6, 0};
        tbl[4] = '{2, 1, 5,  1, 1, 3,  0,  1, 0};
        tdat = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.cfg_period = '0;
        bus.cfg_count = '0;
        bus.adc_valid = 1'b0;
        bus.adc_data = '0;
        bus.m_ready = 1'b0;
        resp_pend = 1'b0;
        mdl_accept = 1'b0;
        exp_mv = 1'b0;
        exp_md = '0;
        exp_ovr = 0;
        lat = 0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        repeat (3) cyc();
        chk("rst_busy", bus.busy, 0);
        chk("rst_adc_start", bus.adc_start, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_err", bus.err_timeout, 0);
        chk("rst_ovr", bus.overrun_cnt, 0);
        chk("rst_missed", bus.missed_cnt, 0);
        rst = 1'b0;
        cyc();

        // burst table
        for (int i = 0; i < 5; i++) begin
            dat_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
            start_run(tbl[i].per, tbl[i].cnt, tbl[i].lat,
                      tbl[i].rdy, 1'b1, s);
            chk("busy_run", bus.busy, 1);
            wait_done(3000);
            chk("n_starts", st_q.size(), tbl[i].nst);
            chk("first_start", first_of(st_q) - s, tbl[i].first);
            for (int k = 1; k < st_q.size(); k++)
                chk("start_spacing", st_q[k] - st_q[k-1], tbl[i].space);
            chk("done_latency", first_of(dn_q) - last_of(st_q),
                tbl[i].lat + 1);
            chk("missed_cnt", bus.missed_cnt, tbl[i].missed);
            chk("overrun_cnt", bus.overrun_cnt, tbl[i].ovr);
            chk("busy_end", bus.busy, 0);
            if (tbl[i].rdy == 1) begin
                chk("xfer_count", xfer_q.size(), tbl[i].nst);
                for (int k = 0; k < xfer_q.size() && k < 4; k++)
                    chk("xfer_data", xfer_q[k], tdat[k]);
            end else begin
                chk("held_valid", bus.m_valid, 1);
                chk("held_data", bus.m_data, 16'h1234);
                rdy_mode = 1;
                cyc();
                chk("one_xfer", xfer_q.size(), 1);
                chk("valid_cleared", bus.m_valid, 0);
            end
            rdy_mode = 1;
            cyc();
            cyc();
        end

        // random bursts against the arithmetic timing model
        for (int it = 0; it < 12; it++) begin
            int p;
            int n;
            int l;
            p = $urandom_range(0, 7);
            n = $urandom_range(1, 4);
            l = $urandom_range(1, 30);
            m = l / (p + 1);
            dat_q.delete();
            start_run(p, n, l, 2, 1'b1, s);
            wait_done(3000);
            chk("rnd_n_starts", st_q.size(), n);
            chk("rnd_first", first_of(st_q) - s, p + 1);
            for (int k = 1; k < st_q.size(); k++)
                chk("rnd_spacing", st_q[k] - st_q[k-1], (m + 1) * (p + 1));
            chk("rnd_done", first_of(dn_q) - last_of(st_q), l + 1);
            chk("rnd_missed", bus.missed_cnt, n * m);
            chk("rnd_overrun", bus.overrun_cnt, exp_ovr);
            rdy_mode = 1;
            cyc();
            cyc();
            chk("rnd_xfer_n", xfer_q.size(), deliv_q.size());
            for (int k = 0; k < xfer_q.size() && k < deliv_q.size(); k++)
                chk("rnd_xfer_data", xfer_q[k], deliv_q[k]);
        end

        // timeout, then a late result arriving in IDLE
        start_run(3, 2, 300, 1, 1'b0, s);
        wait_done(600);
        chk("tmo_n_starts", st_q.size(), 1);
        chk("tmo_done_delay", first_of(dn_q) - first_of(st_q), 255);
        chk("tmo_err", bus.err_timeout, 1);
        chk("tmo_busy", bus.busy, 0);
        for (int k = 0; k < 100 && resp_pend; k++) cyc();
        cyc();
        chk("late_valid_dropped", bus.m_valid, 0);
        chk("late_no_pend", resp_pend, 0);
        start_run(3, 1, 4, 1, 1'b1, s);
        chk("err_cleared", bus.err_timeout, 0);
        wait_done(100);
        cyc();

        // stop while waiting for a tick
        start_run(20, 1, 4, 1, 1'b1, s);
        repeat (4) cyc();
        bus.stop = 1'b1;
        c = cyc_n;
        cyc();
        cyc();
        chk("stopw_done", first_of(dn_q) - c, 1);
        chk("stopw_busy", bus.busy, 0);
        chk("stopw_no_req", st_q.size(), 0);

        // continuous run stopped mid-conversion drains the result
        start_run(5, 0, 20, 1, 1'b0, s);
        for (int k = 0; k < 50 && st_q.size() == 0; k++) cyc();
        r = first_of(st_q);
        for (int k = 0; k < 10 && cyc_n < r + 3; k++) cyc();
        bus.stop = 1'b1;
        cyc();
        wait_done(100);
        chk("drain_done_delay", first_of(dn_q) - r, 21);
        chk("drain_one_req", st_q.size(), 1);
        chk("drain_m_valid", bus.m_valid, 0);
        chk("drain_busy", bus.busy, 0);

        // start and stop together in IDLE
        st_q.delete();
        dn_q.delete();
        bus.cfg_period = 16'd2;
        bus.cfg_count = 16'd1;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        cyc();
        chk("ss_busy", bus.busy, 0);
        repeat (10) cyc();
        chk("ss_no_req", st_q.size(), 0);
        chk("ss_no_done", dn_q.size(), 0);

        // reset during a conversion with a held sample
        dat_q = '{16'hBEEF, 16'hCAFE};
        start_run(4, 0, 3, 0, 1'b1, s);
        for (int k = 0; k < 50 && st_q.size() < 2; k++) cyc();
        chk("rstc_busy_before", bus.busy, 1);
        chk("rstc_held", bus.m_data, 16'hBEEF);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_mv = 1'b0;
        mdl_accept = 1'b0;
        chk("rstc_busy", bus.busy, 0);
        chk("rstc_m_valid", bus.m_valid, 0);
        chk("rstc_m_data", bus.m_data, 0);
        chk("rstc_done", bus.done, 0);
        chk("rstc_adc_start", bus.adc_start, 0);
        chk("rstc_err", bus.err_timeout, 0);
        chk("rstc_ovr", bus.overrun_cnt, 0);
        chk("rstc_missed", bus.missed_cnt, 0);
        repeat (10) cyc();
        chk("rstc_no_req", st_q.size(), 2);
        chk("rstc_idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
